// File: rtl/udp_merger_wrr_pkg.sv
// Shared types for the weighted round-robin UDP TX merger.
package udp_merger_wrr_pkg;

   typedef struct packed {
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [15:0] length;
      logic [15:0] checksum;
   } udp_pkt_hdr;

   localparam int unsigned UDP_PKT_HDR_W = $bits(udp_pkt_hdr);

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      DATA
   } merger_state_e;

endpackage

// File: rtl/merger_wrr_arb.sv
// Winner selection (WRR or fixed priority), rotating pointer and per-turn packet credit.
module merger_wrr_arb #(
   parameter int unsigned NUM_SRCS = 4,
   parameter int unsigned WEIGHT_W = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_SRCS-1:0]          reqs,
   input  logic [NUM_SRCS*WEIGHT_W-1:0] weights,
   input  logic                         mode,
   input  logic                         start,
   input  logic                         pkt_done,
   input  logic                         same_src_req,
   output logic [NUM_SRCS-1:0]          grant_c,
   output logic [$clog2(NUM_SRCS)-1:0]  grant_idx_c,
   output logic                         cont_c
);

   localparam int unsigned IDX_W = $clog2(NUM_SRCS);

   logic [IDX_W-1:0]    ptr_q;
   logic [IDX_W-1:0]    owner_q;
   logic [WEIGHT_W-1:0] credit_q;
   logic                mode_q;
   logic [IDX_W-1:0]    cand;
   logic                found;
   logic [WEIGHT_W-1:0] win_weight_c;

   // First requester scanning from the pointer (WRR) or from index 0 (priority)
   always_comb begin
      grant_c     = '0;
      grant_idx_c = '0;
      found       = 1'b0;
      cand        = '0;
      for (int unsigned i = 0; i < NUM_SRCS; i++) begin
         cand = mode ? IDX_W'(i) : IDX_W'((32'(ptr_q) + i) % NUM_SRCS);
         if (!found && reqs[cand]) begin
            found         = 1'b1;
            grant_c[cand] = 1'b1;
            grant_idx_c   = cand;
         end
      end
   end

   assign win_weight_c = weights[grant_idx_c*WEIGHT_W +: WEIGHT_W];

   // Owner may take another packet only if credit remains after the current one
   assign cont_c = (credit_q > WEIGHT_W'(1)) && same_src_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q    <= '0;
         owner_q  <= '0;
         credit_q <= '0;
         mode_q   <= 1'b0;
      end else if (start) begin
         owner_q  <= grant_idx_c;
         mode_q   <= mode;
         credit_q <= (mode || (win_weight_c == '0)) ? WEIGHT_W'(1) : win_weight_c;
      end else if (pkt_done) begin
         credit_q <= cont_c ? (credit_q - WEIGHT_W'(1)) : '0;
         if (!cont_c && !mode_q) begin
            ptr_q <= (owner_q == IDX_W'(NUM_SRCS - 1)) ? '0 : (owner_q + IDX_W'(1));
         end
      end
   end

endmodule

// File: rtl/udp_merger_wrr.sv
// Packet-atomic N-to-1 UDP TX merger with weighted round robin or fixed priority.
module udp_merger_wrr
   import udp_merger_wrr_pkg::*;
#(
   parameter int unsigned NUM_SRCS   = 4,
   parameter int unsigned DATA_W     = 512,
   parameter int unsigned PADBYTES_W = $clog2(DATA_W/8),
   parameter int unsigned IP_W       = 32,
   parameter int unsigned UDP_HDR_W  = UDP_PKT_HDR_W,
   parameter int unsigned TS_W       = 64,
   parameter int unsigned WEIGHT_W   = 4,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cfg_prio_mode,
   input  logic [NUM_SRCS*WEIGHT_W-1:0]   cfg_weights,

   input  logic [NUM_SRCS-1:0]            srcs_tx_hdr_val,
   output logic [NUM_SRCS-1:0]            srcs_tx_hdr_rdy,
   input  logic [NUM_SRCS*IP_W-1:0]       srcs_tx_src_ip,
   input  logic [NUM_SRCS*IP_W-1:0]       srcs_tx_dst_ip,
   input  logic [NUM_SRCS*UDP_HDR_W-1:0]  srcs_tx_udp_hdr,
   input  logic [NUM_SRCS*TS_W-1:0]       srcs_tx_timestamp,
   input  logic [NUM_SRCS-1:0]            srcs_tx_data_val,
   output logic [NUM_SRCS-1:0]            srcs_tx_data_rdy,
   input  logic [NUM_SRCS*DATA_W-1:0]     srcs_tx_data,
   input  logic [NUM_SRCS-1:0]            srcs_tx_last,
   input  logic [NUM_SRCS*PADBYTES_W-1:0] srcs_tx_padbytes,

   output logic                           dst_tx_hdr_val,
   input  logic                           dst_tx_hdr_rdy,
   output logic [IP_W-1:0]                dst_tx_src_ip,
   output logic [IP_W-1:0]                dst_tx_dst_ip,
   output logic [UDP_HDR_W-1:0]           dst_tx_udp_hdr,
   output logic [TS_W-1:0]                dst_tx_timestamp,
   output logic                           dst_tx_data_val,
   input  logic                           dst_tx_data_rdy,
   output logic [DATA_W-1:0]              dst_tx_data,
   output logic                           dst_tx_last,
   output logic [PADBYTES_W-1:0]          dst_tx_padbytes,

   output logic [NUM_SRCS-1:0]            grant_o,
   output logic [NUM_SRCS*CNT_W-1:0]      pkt_cnt_o
);

   localparam int unsigned IDX_W = $clog2(NUM_SRCS);

   merger_state_e        state_q, state_d;
   logic [NUM_SRCS-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [CNT_W-1:0]     pkt_cnt_q [NUM_SRCS];
   logic                 start_c;
   logic                 pkt_done_c;
   logic                 cont_c;
   logic [NUM_SRCS-1:0]  arb_grant_c;
   logic [IDX_W-1:0]     arb_idx_c;

   merger_wrr_arb #(
      .NUM_SRCS (NUM_SRCS),
      .WEIGHT_W (WEIGHT_W)
   ) u_arb (
      .clk          (clk),
      .rst          (rst),
      .reqs         (srcs_tx_hdr_val),
      .weights      (cfg_weights),
      .mode         (cfg_prio_mode),
      .start        (start_c),
      .pkt_done     (pkt_done_c),
      .same_src_req (srcs_tx_hdr_val[owner_q]),
      .grant_c      (arb_grant_c),
      .grant_idx_c  (arb_idx_c),
      .cont_c       (cont_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_SRCS; i++) begin
            pkt_cnt_q[i] <= '0;
         end
      end else if (pkt_done_c) begin
         pkt_cnt_q[owner_q] <= pkt_cnt_q[owner_q] + CNT_W'(1);
      end
   end

   // Next state plus handshake steering: only the owner ever sees a ready
   always_comb begin
      state_d          = state_q;
      grant_d          = grant_q;
      owner_d          = owner_q;
      start_c          = 1'b0;
      pkt_done_c       = 1'b0;
      srcs_tx_hdr_rdy  = '0;
      srcs_tx_data_rdy = '0;
      dst_tx_hdr_val   = 1'b0;
      dst_tx_data_val  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|srcs_tx_hdr_val) begin
               start_c = 1'b1;
               grant_d = arb_grant_c;
               owner_d = arb_idx_c;
               state_d = HDR;
            end
         end
         HDR: begin
            dst_tx_hdr_val           = srcs_tx_hdr_val[owner_q];
            srcs_tx_hdr_rdy[owner_q] = dst_tx_hdr_rdy;
            if (srcs_tx_hdr_val[owner_q] && dst_tx_hdr_rdy) begin
               state_d = DATA;
            end
         end
         DATA: begin
            dst_tx_data_val           = srcs_tx_data_val[owner_q];
            srcs_tx_data_rdy[owner_q] = dst_tx_data_rdy;
            if (srcs_tx_data_val[owner_q] && dst_tx_data_rdy && srcs_tx_last[owner_q]) begin
               pkt_done_c = 1'b1;
               if (cont_c) begin
                  state_d = HDR;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   assign dst_tx_src_ip    = srcs_tx_src_ip[owner_q*IP_W +: IP_W];
   assign dst_tx_dst_ip    = srcs_tx_dst_ip[owner_q*IP_W +: IP_W];
   assign dst_tx_udp_hdr   = srcs_tx_udp_hdr[owner_q*UDP_HDR_W +: UDP_HDR_W];
   assign dst_tx_timestamp = srcs_tx_timestamp[owner_q*TS_W +: TS_W];
   assign dst_tx_data      = srcs_tx_data[owner_q*DATA_W +: DATA_W];
   assign dst_tx_last      = srcs_tx_last[owner_q];
   assign dst_tx_padbytes  = srcs_tx_padbytes[owner_q*PADBYTES_W +: PADBYTES_W];
   assign grant_o          = grant_q;

   for (genvar g = 0; g < NUM_SRCS; g++) begin : g_cnt
      assign pkt_cnt_o[g*CNT_W +: CNT_W] = pkt_cnt_q[g];
   end

endmodule

// File: tb/tb_udp_merger_wrr.sv
// Directed bench for udp_merger_wrr: per-source packet models feeding a beat scoreboard.
module tb_udp_merger_wrr;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int PW  = 2;
   localparam int IPW = 32;
   localparam int UW  = 64;
   localparam int TW  = 64;
   localparam int WW  = 4;
   localparam int CW  = 32;

   logic            clk;
   logic            rst;
   logic            cfg_prio_mode;
   logic [N*WW-1:0] cfg_weights;
   logic [N-1:0]    srcs_tx_hdr_val, srcs_tx_hdr_rdy;
   logic [N*IPW-1:0] srcs_tx_src_ip, srcs_tx_dst_ip;
   logic [N*UW-1:0] srcs_tx_udp_hdr;
   logic [N*TW-1:0] srcs_tx_timestamp;
   logic [N-1:0]    srcs_tx_data_val, srcs_tx_data_rdy;
   logic [N*DW-1:0] srcs_tx_data;
   logic [N-1:0]    srcs_tx_last;
   logic [N*PW-1:0] srcs_tx_padbytes;
   logic            dst_tx_hdr_val, dst_tx_hdr_rdy;
   logic [IPW-1:0]  dst_tx_src_ip, dst_tx_dst_ip;
   logic [UW-1:0]   dst_tx_udp_hdr;
   logic [TW-1:0]   dst_tx_timestamp;
   logic            dst_tx_data_val, dst_tx_data_rdy;
   logic [DW-1:0]   dst_tx_data;
   logic            dst_tx_last;
   logic [PW-1:0]   dst_tx_padbytes;
   logic [N-1:0]    grant_o;
   logic [N*CW-1:0] pkt_cnt_o;

   int checks, errors, cyc;
   int total[N], nbeats[N], hdr_seq[N], dat_seq[N], beat[N];
   int sb_seq[N];
   int log_src[$];
   int log_cyc[$];
   int open_src, open_seq, open_beat, beats_seen, pkts_seen;
   int rdy_pct;
   logic [N-1:0] hs_h, hs_d;

   udp_merger_wrr #(
      .NUM_SRCS(N), .DATA_W(DW), .PADBYTES_W(PW), .IP_W(IPW),
      .UDP_HDR_W(UW), .TS_W(TW), .WEIGHT_W(WW), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_prio_mode(cfg_prio_mode), .cfg_weights(cfg_weights),
      .srcs_tx_hdr_val(srcs_tx_hdr_val), .srcs_tx_hdr_rdy(srcs_tx_hdr_rdy),
      .srcs_tx_src_ip(srcs_tx_src_ip), .srcs_tx_dst_ip(srcs_tx_dst_ip),
      .srcs_tx_udp_hdr(srcs_tx_udp_hdr), .srcs_tx_timestamp(srcs_tx_timestamp),
      .srcs_tx_data_val(srcs_tx_data_val), .srcs_tx_data_rdy(srcs_tx_data_rdy),
      .srcs_tx_data(srcs_tx_data), .srcs_tx_last(srcs_tx_last),
      .srcs_tx_padbytes(srcs_tx_padbytes),
      .dst_tx_hdr_val(dst_tx_hdr_val), .dst_tx_hdr_rdy(dst_tx_hdr_rdy),
      .dst_tx_src_ip(dst_tx_src_ip), .dst_tx_dst_ip(dst_tx_dst_ip),
      .dst_tx_udp_hdr(dst_tx_udp_hdr), .dst_tx_timestamp(dst_tx_timestamp),
      .dst_tx_data_val(dst_tx_data_val), .dst_tx_data_rdy(dst_tx_data_rdy),
      .dst_tx_data(dst_tx_data), .dst_tx_last(dst_tx_last),
      .dst_tx_padbytes(dst_tx_padbytes),
      .grant_o(grant_o), .pkt_cnt_o(pkt_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] beat_word(int s, int q, int b);
      return {8'(s), 8'(q), 16'(b)};
   endfunction

   function automatic logic [PW-1:0] pad_of(int s, int q);
      return PW'((s + q + 1) % 4);
   endfunction

   function automatic logic [UW-1:0] udp_of(int s, int q);
      return {16'(1000 + s), 16'(2000 + q), 16'(s * 7), 16'(q * 3)};
   endfunction

   task automatic drive_srcs();
      for (int s = 0; s < N; s++) begin
         srcs_tx_hdr_val[s]                = (hdr_seq[s] < total[s]);
         srcs_tx_src_ip[s*IPW +: IPW]      = {8'(s), 24'(hdr_seq[s])};
         srcs_tx_dst_ip[s*IPW +: IPW]      = 32'hC0A8_0000 + 32'(s);
         srcs_tx_udp_hdr[s*UW +: UW]       = udp_of(s, hdr_seq[s]);
         srcs_tx_timestamp[s*TW +: TW]     = 64'(s * 1000 + hdr_seq[s]);
         srcs_tx_data_val[s]               = (dat_seq[s] < hdr_seq[s]);
         srcs_tx_data[s*DW +: DW]          = beat_word(s, dat_seq[s], beat[s]);
         srcs_tx_last[s]                   = (beat[s] == nbeats[s] - 1);
         srcs_tx_padbytes[s*PW +: PW]      = srcs_tx_last[s] ? pad_of(s, dat_seq[s]) : '0;
      end
      dst_tx_hdr_rdy  = ($urandom_range(0, 99) < rdy_pct);
      dst_tx_data_rdy = ($urandom_range(0, 99) < rdy_pct);
   endtask

   task automatic clear_model();
      for (int s = 0; s < N; s++) begin
         total[s] = 0; nbeats[s] = 1; hdr_seq[s] = 0; dat_seq[s] = 0; beat[s] = 0; sb_seq[s] = 0;
      end
      log_src.delete();
      log_cyc.delete();
      open_src = -1; open_seq = 0; open_beat = 0; beats_seen = 0; pkts_seen = 0;
      rdy_pct = 100;
   endtask

   // Runs at the falling edge: scoreboard the dst side and capture source handshakes
   task automatic sample();
      int s, q;
      logic [DW-1:0] exp_w;
      logic exp_last;
      checks++;
      if (((srcs_tx_hdr_rdy | srcs_tx_data_rdy) & ~grant_o) !== '0) begin
         errors++;
         $display("FAIL nonowner_rdy: hdr_rdy %b data_rdy %b grant %b", srcs_tx_hdr_rdy, srcs_tx_data_rdy, grant_o);
      end
      if (dst_tx_hdr_val && dst_tx_hdr_rdy) begin
         s = int'(dst_tx_src_ip[31:24]);
         q = int'(dst_tx_src_ip[23:0]);
         log_src.push_back(s);
         log_cyc.push_back(cyc);
         checks++;
         if (s >= N || open_src != -1 || grant_o !== N'(1 << s) || q != sb_seq[s] ||
             dst_tx_udp_hdr !== udp_of(s, q) || dst_tx_dst_ip !== 32'hC0A8_0000 + 32'(s) ||
             dst_tx_timestamp !== 64'(s * 1000 + q)) begin
            errors++;
            $display("FAIL hdr_accept: src %0d seq %0d grant %b open %0d want seq %0d", s, q, grant_o, open_src, (s < N) ? sb_seq[s] : -1);
         end
         if (s < N) begin
            open_src = s; open_seq = q; open_beat = 0;
         end
      end
      if (dst_tx_data_val && dst_tx_data_rdy) begin
         checks++;
         beats_seen++;
         if (open_src < 0) begin
            errors++;
            $display("FAIL beat_outside_pkt: got data %h want no beat", dst_tx_data);
         end else begin
            exp_w    = beat_word(open_src, open_seq, open_beat);
            exp_last = (open_beat == nbeats[open_src] - 1);
            if (dst_tx_data !== exp_w || dst_tx_last !== exp_last ||
                (exp_last && dst_tx_padbytes !== pad_of(open_src, open_seq))) begin
               errors++;
               $display("FAIL beat: got %h last %b pad %0d want %h last %b pad %0d", dst_tx_data, dst_tx_last,
                        dst_tx_padbytes, exp_w, exp_last, pad_of(open_src, open_seq));
            end
            if (exp_last) begin
               pkts_seen++;
               sb_seq[open_src]++;
               open_src = -1;
            end else begin
               open_beat++;
            end
         end
      end
      hs_h = srcs_tx_hdr_val & srcs_tx_hdr_rdy;
      hs_d = srcs_tx_data_val & srcs_tx_data_rdy;
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      cyc++;
      #1;
      for (int s = 0; s < N; s++) begin
         if (hs_h[s]) hdr_seq[s]++;
         if (hs_d[s]) begin
            if (beat[s] == nbeats[s] - 1) begin
               beat[s] = 0;
               dat_seq[s]++;
            end else begin
               beat[s]++;
            end
         end
      end
      drive_srcs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cfg_prio_mode = 1'b0;
      cfg_weights = {N{4'd1}};
      clear_model();
      drive_srcs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic run_until(int hdrs, int pkts, int budget, string tag);
      int n = 0;
      while ((log_src.size() < hdrs || pkts_seen < pkts) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (log_src.size() < hdrs || pkts_seen < pkts) begin
         errors++;
         $display("FAIL %s_timeout: got hdrs %0d pkts %0d want hdrs %0d pkts %0d", tag, log_src.size(), pkts_seen, hdrs, pkts);
      end
   endtask

   task automatic check_order(string tag, int exp_src[], int exp_gap[]);
      for (int i = 0; i < exp_src.size(); i++) begin
         checks++;
         if (i >= log_src.size()) begin
            errors++;
            $display("FAIL %s_order[%0d]: got none want src %0d", tag, i, exp_src[i]);
         end else if (log_src[i] != exp_src[i] || (i > 0 && log_cyc[i] - log_cyc[i-1] != exp_gap[i])) begin
            errors++;
            $display("FAIL %s_order[%0d]: got src %0d gap %0d want src %0d gap %0d", tag, i, log_src[i],
                     (i > 0) ? log_cyc[i] - log_cyc[i-1] : 0, exp_src[i], exp_gap[i]);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (grant_o !== '0 || pkt_cnt_o !== '0) begin
         errors++;
         $display("FAIL reset_regs: got grant %b cnt %h want 0", grant_o, pkt_cnt_o);
      end
      checks++;
      if (dst_tx_hdr_val !== 1'b0 || dst_tx_data_val !== 1'b0 || srcs_tx_hdr_rdy !== '0 || srcs_tx_data_rdy !== '0) begin
         errors++;
         $display("FAIL reset_hs: got hv %b dv %b hr %b dr %b want 0", dst_tx_hdr_val, dst_tx_data_val, srcs_tx_hdr_rdy, srcs_tx_data_rdy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      int start;
      do_reset();
      repeat (9) tick();
      total[1] = 1;
      nbeats[1] = 3;
      drive_srcs();
      start = cyc;
      run_until(1, 1, 40, "single");
      checks++;
      if (log_src.size() < 1 || log_src[0] != 1 || log_cyc[0] != start + 1) begin
         errors++;
         $display("FAIL single_hdr_latency: got cyc %0d want %0d", (log_cyc.size() > 0) ? log_cyc[0] : -1, start + 1);
      end
      checks++;
      if (beats_seen != 3) begin
         errors++;
         $display("FAIL single_beats: got %0d want 3", beats_seen);
      end
      checks++;
      if (pkt_cnt_o !== {32'd0, 32'd0, 32'd1, 32'd0}) begin
         errors++;
         $display("FAIL single_cnt: got %h want cnt1=1", pkt_cnt_o);
      end
      checks++;
      if (grant_o !== '0) begin
         errors++;
         $display("FAIL single_grant_release: got %b want 0000", grant_o);
      end
   endtask

   task automatic test_wrr_equal();
      int exp_src[], exp_gap[];
      do_reset();
      for (int s = 0; s < N; s++) total[s] = 3;
      drive_srcs();
      run_until(12, 12, 200, "wrr_eq");
      exp_src = new[12];
      exp_gap = new[12];
      for (int i = 0; i < 12; i++) begin
         exp_src[i] = i % 4;
         exp_gap[i] = 3;
      end
      check_order("wrr_eq", exp_src, exp_gap);
      checks++;
      if (pkt_cnt_o !== {32'd3, 32'd3, 32'd3, 32'd3}) begin
         errors++;
         $display("FAIL wrr_eq_cnt: got %h want all 3", pkt_cnt_o);
      end
   endtask

   task automatic test_wrr_weights();
      int exp_src[], exp_gap[];
      do_reset();
      cfg_weights = {4'd0, 4'd3, 4'd1, 4'd2};
      for (int s = 0; s < N; s++) total[s] = 10;
      drive_srcs();
      run_until(10, 0, 200, "wrr_w");
      exp_src = '{0, 0, 1, 2, 2, 2, 3, 0, 0, 1};
      exp_gap = '{0, 2, 3, 3, 2, 2, 3, 3, 2, 3};
      check_order("wrr_w", exp_src, exp_gap);
   endtask

   task automatic test_priority();
      int exp_src[], exp_gap[];
      do_reset();
      cfg_prio_mode = 1'b1;
      cfg_weights = {N{4'd3}};
      total[0] = 3;
      total[2] = 2;
      drive_srcs();
      run_until(5, 5, 100, "prio");
      exp_src = '{0, 0, 0, 2, 2};
      exp_gap = '{0, 3, 3, 3, 3};
      check_order("prio", exp_src, exp_gap);
      checks++;
      if (pkt_cnt_o !== {32'd0, 32'd2, 32'd0, 32'd3}) begin
         errors++;
         $display("FAIL prio_cnt: got %h want cnt0=3 cnt2=2", pkt_cnt_o);
      end
   endtask

   task automatic test_random_rdy();
      do_reset();
      cfg_weights = {N{4'd2}};
      rdy_pct = 50;
      total[0] = 3; total[1] = 3; total[3] = 3;
      nbeats[0] = 8; nbeats[1] = 8; nbeats[3] = 8;
      drive_srcs();
      run_until(9, 9, 3000, "rand");
      checks++;
      if (beats_seen != 72) begin
         errors++;
         $display("FAIL rand_beats: got %0d want 72", beats_seen);
      end
      checks++;
      if (pkt_cnt_o !== {32'd3, 32'd0, 32'd3, 32'd3}) begin
         errors++;
         $display("FAIL rand_cnt: got %h want 3,0,3,3", pkt_cnt_o);
      end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      total[2] = 2;
      nbeats[2] = 8;
      drive_srcs();
      run_until(2, 1, 100, "mid");
      repeat (2) tick();
      checks++;
      if (dst_tx_data_val !== 1'b1 || grant_o !== 4'b0100) begin
         errors++;
         $display("FAIL mid_in_data: got dv %b grant %b want 1 0100", dst_tx_data_val, grant_o);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (dst_tx_hdr_val !== 1'b0 || dst_tx_data_val !== 1'b0 || grant_o !== '0 || pkt_cnt_o !== '0 ||
          srcs_tx_hdr_rdy !== '0 || srcs_tx_data_rdy !== '0) begin
         errors++;
         $display("FAIL mid_reset: got hv %b dv %b grant %b cnt %h want all 0", dst_tx_hdr_val, dst_tx_data_val, grant_o, pkt_cnt_o);
      end
      rst = 1'b0;
      clear_model();
      cyc = 0;
      total[3] = 1;
      nbeats[3] = 2;
      drive_srcs();
      run_until(1, 1, 50, "mid_fresh");
      checks++;
      if (pkt_cnt_o !== {32'd1, 32'd0, 32'd0, 32'd0} || beats_seen != 2) begin
         errors++;
         $display("FAIL mid_fresh_pkt: got cnt %h beats %0d want cnt3=1 beats 2", pkt_cnt_o, beats_seen);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      rst = 1'b1;
      test_reset();
      test_single();
      test_wrr_equal();
      test_wrr_weights();
      test_priority();
      test_random_rdy();
      test_reset_mid_packet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/udp_merger_wrr.md
Name: udp_merger_wrr

Overview:
- N-to-1 UDP TX merger: N sources (header channel plus data channel each) feed one UDP TX engine. Sits between the app-level UDP senders and the UDP/IP TX path.
- Packet-atomic: a source owns the output from header acceptance to its last-beat handshake.
- Adds over the plain round-robin merger: per-source weighted round robin (W packets per turn), a fixed-priority mode, a registered grant, and per-source sent-packet counters.

Parameters:
- NUM_SRCS, 4, number of sources (≥2)
- DATA_W, 512, data beat width in bits
- PADBYTES_W, $clog2(DATA_W/8), padbytes field width
- IP_W, 32, IP address width
- UDP_HDR_W, 64, UDP header width (udp_pkt_hdr)
- TS_W, 64, timestamp width
- WEIGHT_W, 4, per-source weight width
- CNT_W, 32, per-source packet counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cfg_prio_mode  in  1  1 = fixed priority (lowest index wins), 0 = WRR
- cfg_weights  in  NUM_SRCS×WEIGHT_W  packets per turn per source; 0 is treated as 1
- srcs_tx_hdr_val / srcs_tx_hdr_rdy  in/out  NUM_SRCS  per-source header handshake
- srcs_tx_src_ip, srcs_tx_dst_ip  in  NUM_SRCS×IP_W  header fields
- srcs_tx_udp_hdr  in  NUM_SRCS×UDP_HDR_W  header field
- srcs_tx_timestamp  in  NUM_SRCS×TS_W  header field
- srcs_tx_data_val / srcs_tx_data_rdy  in/out  NUM_SRCS  per-source data handshake
- srcs_tx_data  in  NUM_SRCS×DATA_W  data beat
- srcs_tx_last  in  NUM_SRCS  last-beat marker
- srcs_tx_padbytes  in  NUM_SRCS×PADBYTES_W  pad bytes on last beat
- dst_tx_hdr_val/src_ip/dst_ip/udp_hdr/timestamp  out  as above  muxed header; dst_tx_hdr_rdy in 1
- dst_tx_data_val/data/last/padbytes  out  as above  muxed data; dst_tx_data_rdy in 1
- grant_o  out  NUM_SRCS  one-hot current owner, 0 when idle
- pkt_cnt_o  out  NUM_SRCS×CNT_W  packets completed per source

Behaviour:
- Reset: FSM=IDLE, grant_o=0, RR pointer=0, credit=0, pkt_cnt_o=0. All dst vals and all src rdys are 0.
- Non-owner sources always see hdr_rdy=data_rdy=0. Their vals are ignored.
- Dst mux fields follow grant_o. Fields are don't-care when the matching val is 0.
- FSM IDLE:
  - If any hdr_val, pick a winner.
  - WRR: first requester at or after the pointer, cyclically.
  - Priority: lowest index.
  - Register grant_o and load credit = max(cfg_weights[w],1). In priority mode credit = 1.
  - Go to HDR. Arbitration costs exactly 1 cycle: request seen at cycle N gives dst_tx_hdr_val=1 at N+1.
- FSM HDR:
  - dst_tx_hdr_val = owner hdr_val; owner hdr_rdy = dst_tx_hdr_rdy.
  - On handshake go to DATA. Header and data phases never overlap.
- FSM DATA:
  - dst_tx_data_val = owner data_val; owner data_rdy = dst_tx_data_rdy. Beats pass combinationally: no added latency, no loss, no duplication under any rdy pattern.
  - On a last-beat handshake: pkt_cnt[owner]++ (wraps modulo 2^CNT_W) and credit--.
    - If new credit > 0 and owner hdr_val=1 in that cycle: go to HDR with the same owner, no bubble.
    - Otherwise: go to IDLE and clear grant_o. In WRR mode the pointer moves to owner+1 (mod NUM_SRCS).
- cfg_weights and cfg_prio_mode are sampled only in IDLE. Mid-burst changes take effect at the next arbitration.
- A source dropping hdr_val while it still has credit forfeits the rest of its turn.
- Priority mode may starve higher indices. This is intended.
- Reset mid-packet: everything returns to reset state on the next edge. The partial packet is abandoned; upstream and downstream are reset together.

Decomposition:
- udp_pkt_hdr, UDP_HDR_W, and the FSM state enum (IDLE/HDR/DATA) go in packet_struct_pkg / a merger package.
- Sub-module merger_wrr_arb holds the pointer, winner selection, and credit counter.
  - Inputs: reqs, weights, mode, start, pkt_done, same_src_req.
  - Outputs: grant, continue.
- The top level keeps the FSM, the muxes, and the counters.

Test Plan:
- Single source: src1 sends header at cycle 10 plus 3 beats, dst rdy=1 → dst_tx_hdr_val at cycle 11; 3 beats out, last on the 3rd with padbytes intact; pkt_cnt[1]=1; grant_o returns to 0.
- WRR, all weights 1, all 4 sources continuously requesting 1-beat packets → grant order 0,1,2,3,0,1… with one idle cycle between packets.
- Weights {2,1,3,1}, all requesting → order 0,0,1,2,2,2,3,0,0…; no bubble inside a burst.
- Priority mode, src2 and src0 both requesting → src0, src0, … until src0 drops hdr_val, then src2.
- Random dst rdy (50%) on 8-beat packets from 3 sources → scoreboard shows every beat exactly once, in order, never interleaved; non-owner rdys stay 0.
- Assert rst in DATA mid-packet → next cycle all dst vals=0, grant_o=0, pkt_cnt=0; a fresh packet afterwards completes normally.
